lc3_mem_ctrl: RTL

Memory-access initiator between the LC-3 datapath/control FSM and the synchronous RAM responder (CS/WE/ADDR/DataIn in; out/ready back).
- Latches MAR, MDR and R.W on a MIO.EN request.
- Sequences the RAM chip-select/write-enable handshake and captures read data into MDR_OUT.
- Returns the LC-3 memory-ready signal R to the control FSM.

---
 rtl/lc3_mem_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lc3_mem_ctrl                                                 |
// | Description : LC-3 memory-access initiator. Latches MAR/MDR/R.W on a      |
// |               MIO.EN request, runs the CS/WE handshake toward a           |
// |               synchronous RAM, captures read data into MDR_OUT and         |
// |               returns a one-cycle ready pulse R to the control FSM.        |
// |               Optional read timeout enabled by macro LC3_MEM_TIMEOUT_EN.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lc3_mem_ctrl #(
  parameter int WR_CYCLES = 1,   // cycles CS/WE are held for a write (>=1)
  parameter int TIMEOUT   = 15   // max RD_WAIT cycles before abort (timeout build)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mio_en_i,
  input  logic        r_w_i,
  input  logic [15:0] mar_i,
  input  logic [15:0] mdr_in_i,
  output logic [15:0] mdr_out_o,
  output logic        r_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_din_o,
  output logic        ram_cs_o,
  output logic        ram_we_o,
  input  logic [15:0] ram_dout_i,
  input  logic        ram_ready_i
);

  // Write-hold down-counter: loaded with WR_CYCLES-1, transaction ends at 0.
  localparam int c_WR_CNT_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [c_WR_CNT_W-1:0] c_WR_LOAD = c_WR_CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                  state_q;
  logic [15:0]             addr_q;
  logic [15:0]             wdata_q;
  logic [15:0]             mdr_q;
  logic [c_WR_CNT_W-1:0]   wr_cnt_q;
  logic                    cs_q;
  logic                    we_q;
  logic                    r_q;
  logic                    busy_q;

`ifdef LC3_MEM_TIMEOUT_EN
  // Counts completed RD_WAIT cycles; abort once TIMEOUT of them pass.
  localparam int c_TO_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TO_CNT_W-1:0] c_TO_LAST = c_TO_CNT_W'(TIMEOUT - 1);

  logic [c_TO_CNT_W-1:0]   to_cnt_q;
  logic                    err_q;

  assign err_o = err_q;
`else
  // TIMEOUT has no effect in this build; keep it referenced.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign err_o = 1'b0;
`endif

  // All RAM-side and FSM-side outputs come straight from registers.
  assign ram_addr_o = addr_q;
  assign ram_din_o  = wdata_q;
  assign ram_cs_o   = cs_q;
  assign ram_we_o   = we_q;
  assign mdr_out_o  = mdr_q;
  assign r_o        = r_q;
  assign busy_o     = busy_q;

  // Transaction FSM with registered outputs; async reset drops CS/WE at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      addr_q   <= 16'h0000;
      wdata_q  <= 16'h0000;
      mdr_q    <= 16'h0000;
      wr_cnt_q <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      // R is a single-cycle pulse; only the entry into DONE raises it.
      r_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (mio_en_i) begin
            // Request operands are frozen here; later input changes are ignored.
            addr_q  <= mar_i;
            wdata_q <= mdr_in_i;
            busy_q  <= 1'b1;
            cs_q    <= 1'b1;
`ifdef LC3_MEM_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            if (r_w_i) begin
              we_q     <= 1'b1;
              wr_cnt_q <= c_WR_LOAD;
              state_q  <= ST_WR;
            end else begin
              we_q    <= 1'b0;
              state_q <= ST_RD_REQ;
            end
          end
        end

        ST_WR: begin
          // RAM_READY plays no part in a write; only the hold count matters.
          if (wr_cnt_q == '0) begin
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wr_cnt_q <= wr_cnt_q - 1'b1;
          end
        end

        ST_RD_REQ: begin
          // Ready seen here may be left over from an earlier read: skip it.
`ifdef LC3_MEM_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          if (ram_ready_i) begin
            mdr_q   <= ram_dout_i;
            cs_q    <= 1'b0;
            r_q     <= 1'b1;
            state_q <= ST_DONE;
          end
`ifdef LC3_MEM_TIMEOUT_EN
          else if (to_cnt_q == c_TO_LAST) begin
            // Abort: report error and return a defined zero read value.
            mdr_q   <= 16'h0000;
            err_q   <= 1'b1;
            cs_q    <= 1'b0;
            r_q     <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end

        ST_DONE: begin
          // One cycle in IDLE is always spent before the next request is taken.
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          cs_q    <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
